// File: rtl/alu_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | alu_ctrl_pkg : shared state encoding, unit codes, default width    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_ctrl_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] UNIT_ARITH = 2'b00;
   localparam logic [1:0] UNIT_LOGIC = 2'b01;
   localparam logic [1:0] UNIT_CMP   = 2'b10;
   localparam logic [1:0] UNIT_SHIFT = 2'b11;

endpackage

`default_nettype wire

// File: rtl/alu_unit_sel.sv
// +--------------------------------------------------------------------+
// | alu_unit_sel : unit-code decode to one-hot enable, result/flag mux |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_unit_sel
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic [1:0]            unit,
   input  logic                  issue,
   input  logic [DATA_WIDTH-1:0] arith_out,
   input  logic [DATA_WIDTH-1:0] logic_out,
   input  logic [DATA_WIDTH-1:0] cmp_out,
   input  logic [DATA_WIDTH-1:0] shift_out,
   input  logic                  arith_flag,
   input  logic                  logic_flag,
   input  logic                  cmp_flag,
   input  logic                  shift_flag,
   output logic [3:0]            enable_oh,
   output logic [DATA_WIDTH-1:0] sel_data,
   output logic                  sel_flag
);

   // enable_oh bit index equals the unit code
   always_comb begin
      enable_oh       = '0;
      enable_oh[unit] = issue;
   end

   always_comb begin
      sel_data = '0;
      sel_flag = 1'b0;
      case (unit)
         UNIT_ARITH: begin sel_data = arith_out; sel_flag = arith_flag; end
         UNIT_LOGIC: begin sel_data = logic_out; sel_flag = logic_flag; end
         UNIT_CMP:   begin sel_data = cmp_out;   sel_flag = cmp_flag;   end
         UNIT_SHIFT: begin sel_data = shift_out; sel_flag = shift_flag; end
         default:    begin sel_data = '0;        sel_flag = 1'b0;       end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_ctrl.sv
// +--------------------------------------------------------------------+
// | alu_ctrl : single-command issue/wait/return sequencer for 4 units  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int TIMEOUT    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic [3:0]            in_fun,
   output logic [DATA_WIDTH-1:0] a_out,
   output logic [DATA_WIDTH-1:0] b_out,
   output logic [1:0]            fun_out,
   output logic                  arith_enable,
   output logic                  logic_enable,
   output logic                  cmp_enable,
   output logic                  shift_enable,
   input  logic [DATA_WIDTH-1:0] arith_out,
   input  logic [DATA_WIDTH-1:0] logic_out,
   input  logic [DATA_WIDTH-1:0] cmp_out,
   input  logic [DATA_WIDTH-1:0] shift_out,
   input  logic                  arith_flag,
   input  logic                  logic_flag,
   input  logic                  cmp_flag,
   input  logic                  shift_flag,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic [1:0]            res_unit,
   output logic                  res_err
);

   // Counter must hold TIMEOUT itself so it never wraps
   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic [1:0]            r_op;
   logic [1:0]            r_unit;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_res_data;
   logic                  r_res_err;
   logic [3:0]            w_en;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic                  w_sel_flag;
   logic                  w_timeout;

   alu_unit_sel #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_unit_sel (
      .unit       (r_unit),
      .issue      (r_state == ST_ISSUE),
      .arith_out  (arith_out),
      .logic_out  (logic_out),
      .cmp_out    (cmp_out),
      .shift_out  (shift_out),
      .arith_flag (arith_flag),
      .logic_flag (logic_flag),
      .cmp_flag   (cmp_flag),
      .shift_flag (shift_flag),
      .enable_oh  (w_en),
      .sel_data   (w_sel_data),
      .sel_flag   (w_sel_flag)
   );

   assign w_timeout = (r_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      res_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (w_sel_flag || w_timeout) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            res_valid = 1'b1;
            if (res_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a        <= '0;
         r_b        <= '0;
         r_op       <= '0;
         r_unit     <= '0;
         r_cnt      <= '0;
         r_res_data <= '0;
         r_res_err  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a    <= in_a;
                  r_b    <= in_b;
                  r_op   <= in_fun[1:0];
                  r_unit <= in_fun[3:2];
               end
            end
            ST_ISSUE: r_cnt <= '0;
            ST_WAIT: begin
               if (w_sel_flag) begin
                  r_res_data <= w_sel_data;
                  r_res_err  <= 1'b0;
               end else if (w_timeout) begin
                  r_res_data <= '0;
                  r_res_err  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign a_out        = r_a;
   assign b_out        = r_b;
   assign fun_out      = r_op;
   assign res_unit     = r_unit;
   assign res_data     = r_res_data;
   assign res_err      = r_res_err;
   assign arith_enable = w_en[UNIT_ARITH];
   assign logic_enable = w_en[UNIT_LOGIC];
   assign cmp_enable   = w_en[UNIT_CMP];
   assign shift_enable = w_en[UNIT_SHIFT];

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_alu_ctrl : directed self-checking bench for alu_ctrl            |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [3:0]  in_fun;
   logic [15:0] a_out;
   logic [15:0] b_out;
   logic [1:0]  fun_out;
   logic        arith_enable;
   logic        logic_enable;
   logic        cmp_enable;
   logic        shift_enable;
   logic [15:0] arith_out;
   logic [15:0] logic_out = 16'h0;
   logic [15:0] cmp_out;
   logic [15:0] shift_out;
   logic        arith_flag;
   logic        logic_flag;
   logic        logic_flag_m = 1'b0;
   logic        logic_flag_d;
   logic        cmp_flag;
   logic        shift_flag;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic [1:0]  res_unit;
   logic        res_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_ctrl #(
      .DATA_WIDTH (16),
      .TIMEOUT    (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_fun       (in_fun),
      .a_out        (a_out),
      .b_out        (b_out),
      .fun_out      (fun_out),
      .arith_enable (arith_enable),
      .logic_enable (logic_enable),
      .cmp_enable   (cmp_enable),
      .shift_enable (shift_enable),
      .arith_out    (arith_out),
      .logic_out    (logic_out),
      .cmp_out      (cmp_out),
      .shift_out    (shift_out),
      .arith_flag   (arith_flag),
      .logic_flag   (logic_flag),
      .cmp_flag     (cmp_flag),
      .shift_flag   (shift_flag),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .res_unit     (res_unit),
      .res_err      (res_err)
   );

   // Registered logic-unit model: one-cycle flag after its enable
   always_ff @(posedge clk) begin
      if (logic_enable) begin
         case (fun_out)
            2'b00:   logic_out <= a_out & b_out;
            2'b01:   logic_out <= a_out | b_out;
            2'b10:   logic_out <= a_out ^ b_out;
            default: logic_out <= ~a_out;
         endcase
         logic_flag_m <= 1'b1;
      end else begin
         logic_flag_m <= 1'b0;
      end
   end

   assign logic_flag = logic_flag_m | logic_flag_d;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_fun = '0;
      res_ready = 1'b0; arith_out = '0; arith_flag = 1'b0; cmp_out = '0;
      cmp_flag = 1'b0; shift_out = '0; shift_flag = 1'b0; logic_flag_d = 1'b0;
      tick(); tick();
      chk("rst_in_ready", 16'(in_ready), 16'h1);
      chk("rst_res_valid", 16'(res_valid), 16'h0);
      chk("rst_enables", 16'({arith_enable, logic_enable, cmp_enable, shift_enable}), 16'h0);
      chk("rst_a_out", a_out, 16'h0);
      chk("rst_res_data", res_data, 16'h0);
      rst = 1'b1;
      tick();

      // Logic AND, one-cycle unit latency
      in_valid = 1'b1; in_a = 16'hF0F0; in_b = 16'hFF00; in_fun = 4'b0100;
      tick();
      in_valid = 1'b0;
      chk("and_issue_in_ready", 16'(in_ready), 16'h0);
      chk("and_issue_enables", 16'({arith_enable, logic_enable, cmp_enable, shift_enable}), 16'h4);
      chk("and_a_out", a_out, 16'hF0F0);
      chk("and_b_out", b_out, 16'hFF00);
      chk("and_fun_out", 16'(fun_out), 16'h0);
      tick();
      chk("and_wait_enable", 16'(logic_enable), 16'h0);
      chk("and_wait_valid", 16'(res_valid), 16'h0);
      tick();
      chk("and_done_valid", 16'(res_valid), 16'h1);
      chk("and_res_data", res_data, 16'hF000);
      chk("and_res_unit", 16'(res_unit), 16'h1);
      chk("and_res_err", 16'(res_err), 16'h0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("and_hs_valid", 16'(res_valid), 16'h0);
      chk("and_hs_in_ready", 16'(in_ready), 16'h1);

      // Backpressure in DONE with a pending second command
      in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h00F0; in_fun = 4'b0101;
      tick();
      in_a = 16'h0005; in_b = 16'h0003; in_fun = 4'b0110;
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 16'(res_valid), 16'h1);
         chk("bp_data", res_data, 16'h12F4);
         chk("bp_in_ready", 16'(in_ready), 16'h0);
         chk("bp_a_out", a_out, 16'h1234);
         tick();
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("bp_hs_in_ready", 16'(in_ready), 16'h1);
      tick();
      in_valid = 1'b0;
      chk("bp_second_a_out", a_out, 16'h0005);
      chk("bp_second_enable", 16'(logic_enable), 16'h1);
      tick(); tick();
      chk("bp_second_data", res_data, 16'h0006);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // Shift timeout; other units flag but must be ignored
      in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0002; in_fun = 4'b1100;
      shift_out = 16'hABCD; arith_out = 16'h1111; arith_flag = 1'b1;
      cmp_out = 16'h2222; cmp_flag = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("to_shift_enable", 16'({arith_enable, logic_enable, cmp_enable, shift_enable}), 16'h1);
      tick();
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("to_wait_valid", 16'(res_valid), 16'h0);
      end
      tick();
      chk("to_done_valid", 16'(res_valid), 16'h1);
      chk("to_res_data", res_data, 16'h0000);
      chk("to_res_err", 16'(res_err), 16'h1);
      chk("to_res_unit", 16'(res_unit), 16'h3);
      res_ready = 1'b1; arith_flag = 1'b0; cmp_flag = 1'b0;
      tick();
      res_ready = 1'b0;

      // Arith selected: logic flag first must be ignored, arith flag next
      in_valid = 1'b1; in_a = 16'h0010; in_b = 16'h0020; in_fun = 4'b0001;
      arith_out = 16'h5A5A;
      tick();
      in_valid = 1'b0;
      chk("wu_arith_enable", 16'({arith_enable, logic_enable, cmp_enable, shift_enable}), 16'h8);
      chk("wu_fun_out", 16'(fun_out), 16'h1);
      tick();
      logic_flag_d = 1'b1;
      tick();
      chk("wu_ignore_logic", 16'(res_valid), 16'h0);
      logic_flag_d = 1'b0; arith_flag = 1'b1;
      tick();
      arith_flag = 1'b0;
      chk("wu_valid", 16'(res_valid), 16'h1);
      chk("wu_res_data", res_data, 16'h5A5A);
      chk("wu_res_unit", 16'(res_unit), 16'h0);
      chk("wu_res_err", 16'(res_err), 16'h0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // Reset asserted mid-WAIT
      in_valid = 1'b1; in_a = 16'h7777; in_b = 16'h8888; in_fun = 4'b1011;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("mr_in_ready", 16'(in_ready), 16'h1);
      chk("mr_res_valid", 16'(res_valid), 16'h0);
      chk("mr_a_out", a_out, 16'h0);
      chk("mr_b_out", b_out, 16'h0);
      chk("mr_fun_out", 16'(fun_out), 16'h0);
      chk("mr_res_data", res_data, 16'h0);
      chk("mr_cmp_enable", 16'(cmp_enable), 16'h0);
      cmp_flag = 1'b1;
      tick();

      // Release straight into back-to-back commands, res_ready tied high
      rst = 1'b1; cmp_flag = 1'b0; res_ready = 1'b1;
      in_valid = 1'b1; in_a = 16'h00FF; in_b = 16'h0F0F; in_fun = 4'b0100;
      tick();
      chk("bb_first_edge_accept", 16'(logic_enable), 16'h1);
      chk("bb_no_stale_valid", 16'(res_valid), 16'h0);
      in_a = 16'h1100; in_b = 16'h0011; in_fun = 4'b0101;
      tick(); tick();
      chk("bb_r1_valid", 16'(res_valid), 16'h1);
      chk("bb_r1_data", res_data, 16'h000F);
      tick();
      chk("bb_idle_in_ready", 16'(in_ready), 16'h1);
      tick();
      in_valid = 1'b0;
      chk("bb_c2_a_out", a_out, 16'h1100);
      chk("bb_c2_enable", 16'(logic_enable), 16'h1);
      tick(); tick();
      chk("bb_r2_valid", 16'(res_valid), 16'h1);
      chk("bb_r2_data", res_data, 16'h1111);
      tick();
      chk("bb_end_valid", 16'(res_valid), 16'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
